// File: rtl/player_sprite_reader.sv
// Player sprite ROM read engine: raster -> ROM address, colour-keyed pixel out, 2-frame walk animation.
// Optional horizontal mirroring via `define PLAYER_MIRROR_EN (adds face_left input).
module player_sprite_reader #(
    parameter int          ADDRESS     = 11,
    parameter int          COLOR_BITS  = 24,
    parameter int          SPR_W_LOG2  = 5,
    parameter int          SPR_H_LOG2  = 5,
    parameter int          ANIM_PERIOD = 8,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  frame_start,
    input  logic [9:0]            pos_x,
    input  logic [9:0]            pos_y,
    input  logic                  move,
`ifdef PLAYER_MIRROR_EN
    input  logic                  face_left,
`endif
    output logic [ADDRESS-1:0]    rom_addr,
    input  logic [COLOR_BITS-1:0] rom_dout,
    output logic                  pix_valid,
    output logic [COLOR_BITS-1:0] pix_color
);

    localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(ANIM_PERIOD - 1);
    localparam logic [10:0]           SPR_W    = 11'(1 << SPR_W_LOG2);
    localparam logic [10:0]           SPR_H    = 11'(1 << SPR_H_LOG2);
    localparam logic [COLOR_BITS-1:0] KEY      = KEY_COLOR[COLOR_BITS-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_A = 2'd1,
        WALK_B = 2'd2
    } anim_state_e;

    anim_state_e            state_q, state_d;
    logic [CNT_W-1:0]       anim_cnt_q, anim_cnt_d;
    logic [9:0]             px_q, px_d, py_q, py_d;
    logic [ADDRESS-1:0]     rom_addr_q, rom_addr_d;
    logic                   in1_q, in1_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [COLOR_BITS-1:0]  pix_color_q, pix_color_d;
    logic [10:0]            dx, dy;
    logic                   fbit;
    logic [SPR_W_LOG2-1:0]  x_idx;
`ifdef PLAYER_MIRROR_EN
    logic                   face_q, face_d;
`endif

    // Frame-boundary updates: position latch and walk-animation state
    always_comb begin
        px_d       = px_q;
        py_d       = py_q;
        state_d    = state_q;
        anim_cnt_d = anim_cnt_q;
`ifdef PLAYER_MIRROR_EN
        face_d     = face_q;
`endif
        if (frame_start) begin
            px_d = pos_x;
            py_d = pos_y;
`ifdef PLAYER_MIRROR_EN
            face_d = face_left;
`endif
            case (state_q)
                IDLE: begin
                    state_d    = move ? WALK_A : IDLE;
                    anim_cnt_d = '0;
                end
                WALK_A, WALK_B: begin
                    // Stopping wins over the step count
                    if (!move) begin
                        state_d    = IDLE;
                        anim_cnt_d = '0;
                    end else if (anim_cnt_q == CNT_LAST) begin
                        state_d    = (state_q == WALK_A) ? WALK_B : WALK_A;
                        anim_cnt_d = '0;
                    end else begin
                        state_d    = state_q;
                        anim_cnt_d = anim_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    anim_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Stage 1: sprite-box test and ROM address; unsigned dx/dy put left/above the box outside
    always_comb begin
        dx    = {1'b0, hcount} - {1'b0, px_q};
        dy    = {1'b0, vcount} - {1'b0, py_q};
        fbit  = (state_q == WALK_B);
        in1_d = (dx < SPR_W) && (dy < SPR_H);
`ifdef PLAYER_MIRROR_EN
        if (face_q) begin
            x_idx = {SPR_W_LOG2{1'b1}} - dx[SPR_W_LOG2-1:0];
        end else begin
            x_idx = dx[SPR_W_LOG2-1:0];
        end
`else
        x_idx = dx[SPR_W_LOG2-1:0];
`endif
        if (in1_d) begin
            rom_addr_d = {fbit, dy[SPR_H_LOG2-1:0], x_idx};
        end else begin
            rom_addr_d = '0;
        end
    end

    // Stage 2: colour key on the ROM data returned for the stage-1 address
    always_comb begin
        pix_valid_d = in1_q && (rom_dout != KEY);
        if (pix_valid_d) begin
            pix_color_d = rom_dout;
        end else begin
            pix_color_d = '0;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            anim_cnt_q  <= '0;
            px_q        <= 10'd0;
            py_q        <= 10'd0;
            rom_addr_q  <= '0;
            in1_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_color_q <= '0;
`ifdef PLAYER_MIRROR_EN
            face_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            anim_cnt_q  <= anim_cnt_d;
            px_q        <= px_d;
            py_q        <= py_d;
            rom_addr_q  <= rom_addr_d;
            in1_q       <= in1_d;
            pix_valid_q <= pix_valid_d;
            pix_color_q <= pix_color_d;
`ifdef PLAYER_MIRROR_EN
            face_q      <= face_d;
`endif
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_color = pix_color_q;

endmodule

// File: tb/tb_player_sprite_reader.sv
// Scoreboard bench for player_sprite_reader: driver queues expected address/pixel, monitor compares.
module tb_player_sprite_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  hcount = 10'd0, vcount = 10'd0, pos_x = 10'd0, pos_y = 10'd0;
    logic        frame_start = 1'b0, move = 1'b0, face_left = 1'b0;
    logic [10:0] rom_addr;
    logic [23:0] rom_dout;
    logic        pix_valid;
    logic [23:0] pix_color;

    logic [23:0] mem [0:2047];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;

`ifdef PLAYER_MIRROR_EN
    localparam logic [10:0] MIR_A = 11'd31;
`else
    localparam logic [10:0] MIR_A = 11'd0;
`endif
    localparam logic [23:0] KEY = 24'hFF00FF;

    typedef struct { int due; logic [10:0] addr; } a_t;
    typedef struct { int due; logic v; logic [23:0] c; } p_t;
    a_t aq[$];
    p_t pq[$];

    player_sprite_reader dut (
        .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .move(move),
`ifdef PLAYER_MIRROR_EN
        .face_left(face_left),
`endif
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .pix_valid(pix_valid), .pix_color(pix_color)
    );

    assign rom_dout = mem[rom_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Drive one raster pixel; inb/ea are the hand-computed box test and address
    task automatic drv(input int h, input int v, input logic inb, input logic [10:0] ea);
        a_t a;
        p_t p;
        @(negedge clk);
        frame_start = 1'b0;
        hcount = 10'(h);
        vcount = 10'(v);
        a.due = cyc + 1;
        a.addr = inb ? ea : 11'd0;
        p.due = cyc + 2;
        p.v = inb && (mem[ea] != KEY);
        p.c = p.v ? mem[ea] : 24'd0;
        aq.push_back(a);
        pq.push_back(p);
    endtask

    // frame_start pulse, raster parked far outside any box
    task automatic fs(input int x, input int y, input logic mv, input logic fl);
        a_t a;
        p_t p;
        @(negedge clk);
        frame_start = 1'b1;
        pos_x = 10'(x);
        pos_y = 10'(y);
        move = mv;
        face_left = fl;
        hcount = 10'd1023;
        vcount = 10'd1023;
        a.due = cyc + 1;
        a.addr = 11'd0;
        p.due = cyc + 2;
        p.v = 1'b0;
        p.c = 24'd0;
        aq.push_back(a);
        pq.push_back(p);
    endtask

    // Monitor: compare whatever is due this cycle, away from the clock edge
    initial begin
        a_t a;
        p_t p;
        forever begin
            @(posedge clk);
            #2;
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                a = aq.pop_front();
                chk("rom_addr", 32'(rom_addr), 32'(a.addr));
            end
            while (pq.size() > 0 && pq[0].due <= cyc) begin
                p = pq.pop_front();
                chk("pix_valid", 32'(pix_valid), 32'(p.v));
                chk("pix_color", 32'(pix_color), 32'(p.c));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 24'h100000 + 24'(i);
        mem[7] = KEY;
        mem[8] = 24'h00FF00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_color", 32'(pix_color), 32'd0);
        rst_n = 1'b1;

        // No frame_start yet: box at (0,0)
        drv(0, 0, 1'b1, 11'd0);
        drv(5, 3, 1'b1, 11'd101);

        // Position (100,50) and box edges
        fs(100, 50, 1'b0, 1'b0);
        drv(100, 50, 1'b1, 11'd0);
        drv(115, 60, 1'b1, 11'd335);
        drv(131, 81, 1'b1, 11'd1023);
        drv(132, 50, 1'b0, 11'd0);
        drv(99, 50, 1'b0, 11'd0);
        drv(100, 82, 1'b0, 11'd0);
        drv(100, 49, 1'b0, 11'd0);

        // Colour key vs opaque
        drv(107, 50, 1'b1, 11'd7);
        drv(108, 50, 1'b1, 11'd8);

        // Position change without frame_start is ignored
        pos_x = 10'd300;
        drv(100, 50, 1'b1, 11'd0);
        fs(300, 50, 1'b0, 1'b0);
        drv(300, 50, 1'b1, 11'd0);
        drv(100, 50, 1'b0, 11'd0);
        drv(331, 81, 1'b1, 11'd1023);

        // Walk animation: 8 frames fbit=0, then fbit=1
        for (int k = 1; k <= 16; k++) begin
            fs(100, 50, 1'b1, 1'b0);
            drv(100, 50, 1'b1, (k <= 8) ? 11'd0 : 11'd1024);
        end
        drv(131, 81, 1'b1, 11'd2047);
        fs(100, 50, 1'b0, 1'b0);
        drv(100, 50, 1'b1, 11'd0);

        // Mirror (address 31 only when the feature is built in)
        fs(100, 50, 1'b0, 1'b1);
        drv(100, 50, 1'b1, MIR_A);
        drv(131, 50, 1'b1, 11'd31 - MIR_A);
        fs(100, 50, 1'b0, 1'b0);
        drv(100, 50, 1'b1, 11'd0);

        // Reset mid-frame: outputs drop immediately, position back to 0
        repeat (3) @(negedge clk);
        hcount = 10'd131;
        vcount = 10'd81;
        repeat (2) @(negedge clk);
        chk("pre_rst_addr", 32'(rom_addr), 32'd1023);
        chk("pre_rst_valid", 32'(pix_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_addr", 32'(rom_addr), 32'd0);
        chk("midrst_valid", 32'(pix_valid), 32'd0);
        chk("midrst_color", 32'(pix_color), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(5, 3, 1'b1, 11'd101);
        drv(100, 50, 1'b0, 11'd0);

        repeat (4) @(negedge clk);
        chk("queues_drained", 32'(aq.size() + pq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
